periph_obi_arbiter: RTL
=======================

# periph_obi_arbiter

Arbitrates NumReq OBI masters onto the single OBI slave port of `peripheral_subsystem` (`slave_req_i`/`slave_resp_o`). It holds an ungranted request stable until it is granted and tracks outstanding transactions in an ID FIFO, so each `rvalid`/`rdata` is returned only to the requester that issued the transaction. Its main use is sharing the peripheral bus between the core data port and the DMA or an external debug master without adding another crossbar level.

## Interface
- `NumReq`, default 2: number of requesters, 2..8.
- `MaxOutstanding`, default 2: ID FIFO depth, 1..4. This is the maximum number of transactions granted but not yet answered.
- `clk_i`  in  1: clock.
- `rst_ni`  in  1: reset, asynchronous, active-low.
- `req_i`  in  `obi_pkg::obi_req_t [NumReq]`: requester requests.
- `resp_o`  out  `obi_pkg::obi_resp_t [NumReq]`: per-requester `gnt`/`rvalid`/`rdata`.
- `slave_req_o`  out  `obi_pkg::obi_req_t`: towards the peripheral subsystem.
- `slave_resp_i`  in  `obi_pkg::obi_resp_t`: from the peripheral subsystem.
- `outstanding_o`  out  `$clog2(MaxOutstanding+1)`: current FIFO occupancy.
- `protocol_err_o`  out  1: sticky flag, set when `rvalid` arrives with an empty FIFO.

## Operation
- Eligible requesters: all `i` with `req_i[i].req=1`, and only while occupancy < MaxOutstanding. When the FIFO is full, `slave_req_o.req=0` and every `gnt=0`.
- Selection uses the priority scheme set by the macro (see Configuration). `slave_req_o` is a copy of `req_i[sel]`. `resp_o[sel].gnt` is `slave_resp_i.gnt`; every other `gnt` is 0.
- Hold state machine:
  - States: FREE and HOLD(idx).
  - FREE → HOLD(sel) when `slave_req_o.req=1` and `gnt=0`.
  - HOLD(idx) forces `sel=idx` regardless of other requests.
  - HOLD → FREE on the handshake (`req & gnt`).
  - If `req_i[idx].req` drops while in HOLD (a protocol violation by the master), return to FREE the next cycle.
- On a handshake:
  - Push `sel` into the ID FIFO.
  - Round-robin mode only: the pointer becomes `(sel+1) mod NumReq`.
- On `slave_resp_i.rvalid`:
  - Pop the FIFO head `h`.
  - `resp_o[h].rvalid=1` and `resp_o[h].rdata=slave_resp_i.rdata`.
  - All other requesters get `rvalid=0`. `rdata` is broadcast to all requesters (don't-care unless `rvalid`).
- Push and pop in the same cycle are allowed when not full; occupancy is unchanged.
- `rvalid` with an empty FIFO: nothing is routed, and `protocol_err_o` is set and stays set until reset.

## Timing
- `req`→`slave_req_o`, `gnt`→`resp_o.gnt`, and `rvalid`→`resp_o.rvalid` are all combinational (zero added latency).
- The FIFO, the round-robin pointer and the hold state update on the rising edge of `clk_i`.
- Reset values:
  - FIFO empty, so `outstanding_o=0`.
  - Pointer = 0, state = FREE, `protocol_err_o=0`.
  - `slave_req_o` follows the inputs, which gives `req=0` when no requester is active.
  - All `resp_o` fields = 0 when the slave is idle.
- Reset asserted mid-transaction drops all pending IDs. A late `rvalid` after reset release sets `protocol_err_o`; this is documented and expected, and reset of master and slave is system-level.
- A pushed entry can pop at the earliest in the next cycle. The FIFO has no fall-through, matching the `obi_fifo`/`periph_to_reg` response latency of ≥1 cycle.

## Configuration
- Macro: `PERIPH_ARB_RR_EN`.
- Defined: round-robin arbitration. The search starts at the pointer and takes the first eligible index in ascending order modulo NumReq.
- Undefined: fixed priority, lowest index wins. The pointer register is not built.
- The hold rule, ID FIFO and error flag are identical in both builds.

## Structure
- `periph_obi_arbiter_pkg` contains:
  - the `req_idx_t` typedef (`logic [$clog2(NumReq)-1:0]`, with a minimum width of 1);
  - the state enum `arb_state_e` (FREE, HOLD);
  - the constant `MAX_NUM_REQ = 8`.
- One sub-module, `periph_arb_id_fifo`: a parameterised-depth, non-fall-through FIFO with push, pop, head, count, full and empty.

## Test plan
- Single requester: req0 write to 0x2000_0000 with gnt delayed 2 cycles → `slave_req_o` stable for 3 cycles, one push, `rvalid` returned only on `resp_o[0]`.
- Contention, RR build, NumReq=2: both masters issue 4 back-to-back reads with the slave always granting → grant order 0,1,0,1,0,1,0,1, and each `rdata` reaches its issuer.
- Contention, fixed-priority build: the same stimulus → req0 wins all 4 grants before req1 gets any.
- Hold: req0 presented with gnt=0 while req1 rises the next cycle → `sel` stays 0 until gnt; no switch in the RR build even with the pointer at 1.
- FIFO full, MaxOutstanding=2: two grants with no `rvalid` → `outstanding_o=2`, `slave_req_o.req=0`, all `gnt=0`. One `rvalid` → a new grant is accepted the next cycle.
- Spurious `rvalid` after reset → no `resp_o.rvalid`, `protocol_err_o=1` and held.

Source files
------------

// File: rtl/obi_pkg.sv
// Minimal OBI request/response types shared by the peripheral bus masters and slaves.
package obi_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/periph_obi_arbiter_pkg.sv
// Shared types for the peripheral OBI arbiter: requester index, hold-FSM states, limits.
package periph_obi_arbiter_pkg;

  localparam int unsigned MAX_NUM_REQ = 8;

  // Wide enough for any legal NumReq; the top derives its own exact index width.
  localparam int unsigned REQ_IDX_W = (MAX_NUM_REQ > 1) ? $clog2(MAX_NUM_REQ) : 1;

  typedef logic [REQ_IDX_W-1:0] req_idx_t;

  typedef enum logic {
    FREE = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

endpackage

// File: rtl/periph_arb_id_fifo.sv
// Non-fall-through ID FIFO: an entry pushed this cycle becomes visible at the head next cycle.
module periph_arb_id_fifo
  import periph_obi_arbiter_pkg::*;
#(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 1,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] head_o,
  output logic [CntW-1:0]  count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/periph_obi_arbiter.sv
// Arbitrates NumReq OBI masters onto one peripheral slave and routes responses via an ID FIFO.
// Build option: define PERIPH_ARB_RR_EN for round-robin, otherwise fixed (lowest index) priority.
module periph_obi_arbiter
  import periph_obi_arbiter_pkg::*;
#(
  parameter int unsigned NumReq         = 2,
  parameter int unsigned MaxOutstanding = 2,
  localparam int unsigned CntW          = $clog2(MaxOutstanding + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  obi_pkg::obi_req_t   req_i [NumReq],
  output obi_pkg::obi_resp_t  resp_o [NumReq],
  output obi_pkg::obi_req_t   slave_req_o,
  input  obi_pkg::obi_resp_t  slave_resp_i,
  output logic [CntW-1:0]     outstanding_o,
  output logic                protocol_err_o
);

  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

  arb_state_e        state_q, state_d;
  logic [IdxW-1:0]   hold_idx_q, hold_idx_d;
  logic              err_q, err_d;
  logic [IdxW-1:0]   sel;
  logic [NumReq-1:0] eligible;
  logic              handshake;
  logic              pop;
  logic              fifo_full, fifo_empty;
  logic [IdxW-1:0]   fifo_head;

  periph_arb_id_fifo #(
    .Depth (MaxOutstanding),
    .Width (IdxW)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (handshake),
    .data_i  (sel),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .count_o (outstanding_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    for (int i = 0; i < int'(NumReq); i++) eligible[i] = req_i[i].req & ~fifo_full;
  end

`ifdef PERIPH_ARB_RR_EN
  logic [IdxW-1:0] ptr_q, ptr_d;

  always_comb begin
    logic found;
    int   j;
    found = 1'b0;
    j     = 0;
    sel   = '0;
    if (state_q == HOLD) begin
      sel = hold_idx_q;
    end else begin
      for (int k = 0; k < int'(NumReq); k++) begin
        j = (int'(ptr_q) + k) % int'(NumReq);
        if (!found && eligible[j]) begin
          sel   = IdxW'(j);
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (handshake) ptr_d = (sel == IdxW'(NumReq - 1)) ? '0 : sel + IdxW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end
`else
  always_comb begin
    sel = '0;
    if (state_q == HOLD) begin
      sel = hold_idx_q;
    end else begin
      // Descending scan so the lowest eligible index is the last (winning) write.
      for (int k = int'(NumReq) - 1; k >= 0; k--) begin
        if (eligible[k]) sel = IdxW'(k);
      end
    end
  end
`endif

  always_comb begin
    slave_req_o     = req_i[sel];
    slave_req_o.req = req_i[sel].req & ~fifo_full;
  end

  assign handshake = slave_req_o.req & slave_resp_i.gnt;
  assign pop       = slave_resp_i.rvalid & ~fifo_empty;

  always_comb begin
    for (int i = 0; i < int'(NumReq); i++) begin
      resp_o[i]       = '0;
      resp_o[i].rdata = slave_resp_i.rdata;
    end
    resp_o[sel].gnt = slave_resp_i.gnt & slave_req_o.req;
    if (pop) resp_o[fifo_head].rvalid = 1'b1;
  end

  // Hold an unanswered request on the bus until the slave grants it.
  always_comb begin
    state_d    = state_q;
    hold_idx_d = hold_idx_q;
    unique case (state_q)
      FREE: begin
        if (slave_req_o.req && !slave_resp_i.gnt) begin
          state_d    = HOLD;
          hold_idx_d = sel;
        end
      end
      HOLD: begin
        if (handshake || !req_i[hold_idx_q].req) state_d = FREE;
      end
      default: state_d = FREE;
    endcase
  end

  assign err_d          = err_q | (slave_resp_i.rvalid & fifo_empty);
  assign protocol_err_o = err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= FREE;
      hold_idx_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_idx_q <= hold_idx_d;
      err_q      <= err_d;
    end
  end

endmodule
